// File: rtl/hart_pkg.sv
// Shared definitions for hart retire consumers: monitor states, dmem byte-mask
// shapes, RISC-V opcodes, and the dmem access legality rule.
package hart_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_HALTED  = 2'b01,
    ST_TIMEOUT = 2'b10
  } state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // A load or store may touch a naturally aligned byte, halfword or word.
  // An access that is both a load and a store is never legal.
  function automatic logic dmem_access_legal(input logic       ren,
                                             input logic       wen,
                                             input logic [1:0] a,
                                             input logic [3:0] mask);
    logic ok;
    ok = 1'b0;
    if (mask == 4'(MASK_B << a))                 ok = 1'b1;
    if (!a[0] && (mask == 4'(MASK_H << a)))      ok = 1'b1;
    if ((a == 2'd0) && (mask == MASK_W))         ok = 1'b1;
    if (ren && wen)                              ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/retire_monitor_if.sv
// Hart retire bus: one retiring instruction per cycle while valid is high.
interface retire_monitor_if;
  logic        valid;
  logic        trap;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] dmem_addr;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [3:0]  dmem_mask;

  modport master (
    output valid, trap, halt, pc, next_pc,
    output dmem_addr, dmem_ren, dmem_wen, dmem_mask
  );

  modport slave (
    input valid, trap, halt, pc, next_pc,
    input dmem_addr, dmem_ren, dmem_wen, dmem_mask
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous reset that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_en && !(&cnt_q)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/retire_monitor.sv
// Retire-stream monitor: run/halt/timeout tracking, event counters, and sticky
// PC-continuity and dmem-mask error flags.
module retire_monitor
  import hart_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned TIMEOUT    = 40000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  retire_monitor_if.slave    rif,
  output logic [1:0]         o_state,
  output logic               o_done,
  output logic [CNT_W-1:0]   o_cycles,
  output logic [CNT_W-1:0]   o_instret,
  output logic [CNT_W-1:0]   o_loads,
  output logic [CNT_W-1:0]   o_stores,
  output logic [CNT_W-1:0]   o_traps,
  output logic               o_pc_err,
  output logic [31:0]        o_pc_err_pc,
  output logic               o_mask_err
);

  localparam int unsigned CMP_W = (CNT_W > 32) ? CNT_W : 32;

  state_e      state_q;
  logic        done_q;
  logic        pc_err_q;
  logic [31:0] pc_err_pc_q;
  logic [31:0] exp_pc_q;
  logic        mask_err_q;

  logic             run;
  logic             ret;
  logic             pc_bad;
  logic             mask_bad;
  logic             timeout_hit;
  logic [CNT_W-1:0] cyc_next;
  logic             unused_addr_hi;

  assign run         = (state_q == ST_RUN);
  assign ret         = run & rif.valid;
  assign pc_bad      = (rif.pc != exp_pc_q);
  assign mask_bad    = (rif.dmem_ren | rif.dmem_wen) &
                       !dmem_access_legal(rif.dmem_ren, rif.dmem_wen,
                                          rif.dmem_addr[1:0], rif.dmem_mask);
  // Timeout compares against the value the cycle counter is about to take.
  assign cyc_next    = (&o_cycles) ? o_cycles : o_cycles + CNT_W'(1);
  assign timeout_hit = (CMP_W'(cyc_next) == CMP_W'(TIMEOUT));
  assign unused_addr_hi = ^rif.dmem_addr[31:2];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_RUN;
      done_q      <= 1'b0;
      pc_err_q    <= 1'b0;
      pc_err_pc_q <= '0;
      exp_pc_q    <= RESET_ADDR;
      mask_err_q  <= 1'b0;
    end else if (run) begin
      if (rif.valid) begin
        exp_pc_q <= rif.next_pc;
        if (pc_bad) begin
          pc_err_q <= 1'b1;
          if (!pc_err_q) pc_err_pc_q <= rif.pc;
        end
        if (mask_bad) mask_err_q <= 1'b1;
      end
      if (ret && rif.halt) begin
        state_q <= ST_HALTED;
        done_q  <= 1'b1;
      end else if (timeout_hit) begin
        state_q <= ST_TIMEOUT;
        done_q  <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cycles (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(run), .o_cnt(o_cycles)
  );
  sat_counter #(.W(CNT_W)) u_instret (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(ret), .o_cnt(o_instret)
  );
  sat_counter #(.W(CNT_W)) u_loads (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(ret & rif.dmem_ren), .o_cnt(o_loads)
  );
  sat_counter #(.W(CNT_W)) u_stores (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(ret & rif.dmem_wen), .o_cnt(o_stores)
  );
  sat_counter #(.W(CNT_W)) u_traps (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(ret & rif.trap), .o_cnt(o_traps)
  );

  assign o_state     = state_q;
  assign o_done      = done_q;
  assign o_pc_err    = pc_err_q;
  assign o_pc_err_pc = pc_err_pc_q;
  assign o_mask_err  = mask_err_q;

endmodule
